spi_adc_capture: RTL and testbench
==================================

Name: spi_adc_capture

Overview:
Parametrised SPI capture engine for multi-channel conversion ADCs such as the LTC1407A dual 14-bit part. It generates the conversion strobe and SPI clock, then deserialises NUM_CH channel words from one MISO line, MSB first. Frames run single-shot or back-to-back, and results are delivered on a valid/ack handshake with sticky overrun detection. It replaces the fixed 34-clock dual-channel capture logic and sits between the board-level SPI pins and the sample-processing datapath.

Parameters:
DATA_W, 14, bits per channel word
NUM_CH, 2, channels per frame (1..8)
GAP_BITS, 2, idle SCK cycles before each channel word
TAIL_BITS, 2, idle SCK cycles after the last channel word
HALF_DIV, 2, clk cycles per SCK half-period (>=1); SCK = clk/(2*HALF_DIV)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to begin a frame; honoured only in IDLE
cont  in  1  continuous mode: while high, a new frame starts immediately after DONE
spi_miso  in  1  ADC serial data
data_ack  in  1  consumer accepts adc_data; clears data_valid
spi_sck  out  1  SPI clock to ADC, idle low
adc_conv  out  1  conversion strobe, active high
busy  out  1  high in CONV, SHIFT and DONE
adc_data  out  NUM_CH*DATA_W  channel c in bits [c*DATA_W +: DATA_W]
data_valid  out  1  adc_data holds an unacknowledged frame
overrun  out  1  sticky: a frame completed while data_valid was still high

Behaviour:
- Derived constants: FRAME_BITS = NUM_CH*(GAP_BITS+DATA_W) + TAIL_BITS (34 at defaults); P = 2*HALF_DIV.
- Reset (rst high at a clk edge): state goes to IDLE. All outputs are 0: spi_sck, adc_conv, busy, adc_data, data_valid, overrun. Internal counters and shift registers are cleared. This applies mid-frame too; no partial data is published.
- FSM states: IDLE, CONV, SHIFT, DONE.
- IDLE -> CONV on (start | cont). The state register is updated at that edge.
- CONV: adc_conv=1 and spi_sck=0 for exactly P cycles, then -> SHIFT.
- SHIFT: FRAME_BITS SCK periods. Each period is spi_sck=1 for HALF_DIV cycles, then spi_sck=0 for HALF_DIV cycles. adc_conv=0.
  - spi_miso is sampled at the clk edge where spi_sck goes 1->0. The ADC changes data on rising SCK.
  - Bit index b counts 0..FRAME_BITS-1.
  - Channel c captures bit b when c*(GAP_BITS+DATA_W)+GAP_BITS <= b < (c+1)*(GAP_BITS+DATA_W). The first captured bit is the MSB.
  - Gap and tail bits are clocked but discarded.
  - After the last falling edge -> DONE.
- DONE (1 cycle):
  - The full frame is copied to adc_data and data_valid is set.
  - If data_valid was already 1 and data_ack is not high this cycle, overrun is set. The new data still overwrites the old.
  - Next state -> CONV if cont=1, else IDLE.
- Latency: with the start edge at cycle 0, adc_conv is high in cycles 1..P. data_valid first reads 1 in cycle P*(FRAME_BITS+1)+1, which is 141 at defaults.
- Continuous mode: the CONV of the next frame begins the cycle after DONE, so the frame period is P*(FRAME_BITS+1)+1 cycles.
- Handshake: data_valid clears on the edge after data_ack=1. If data_ack coincides with a DONE write, data_valid stays 1 (new frame) and no overrun is flagged. data_ack while data_valid=0 is ignored.
- start while busy is ignored.
- Dropping cont mid-frame finishes the current frame normally, then returns to IDLE.
- adc_data changes only in DONE.
- overrun clears only on rst.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Defaults, start pulse, ADC model drives ch0=14'b00001010001001 and ch1=14'b00001101101001 in bits 2..15 and 18..31, with 0 elsewhere -> adc_data=={ch1,ch0}; data_valid rises at cycle 141; exactly 34 SCK rising edges; adc_conv high for 4 cycles.
- Gap/tail immunity: drive spi_miso=1 during bits 0,1,16,17,32,33, with same words as above -> identical adc_data.
- Continuous with no data_ack for 3 frames -> overrun=1 after frame 2. Then hold data_ack high continuously -> no overrun on a fresh run; data_valid period 141 cycles.
- Assert rst at bit 20 of a frame -> next cycle spi_sck=0, adc_conv=0, busy=0, adc_data=0, data_valid=0. A following start produces a clean full frame.
- start pulsed during SHIFT, and cont dropped during SHIFT -> no extra frame; IDLE after DONE; busy falls the cycle after data_valid rises.
- NUM_CH=4, DATA_W=12, GAP_BITS=1, TAIL_BITS=0, HALF_DIV=1, words 12'hA5C, 12'h3F0, 12'h001, 12'hFFF -> adc_data=={12'hFFF,12'h001,12'h3F0,12'hA5C}; FRAME_BITS=52; data_valid at cycle 2*53+1=107.

Source files
------------

// File: rtl/spi_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : spi_adc_capture
// Description : Conversion-strobe and SPI capture engine for multi-channel
//               serial ADCs; publishes NUM_CH words on a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_adc_capture #(
    parameter int DATA_W    = 14,
    parameter int NUM_CH    = 2,
    parameter int GAP_BITS  = 2,
    parameter int TAIL_BITS = 2,
    parameter int HALF_DIV  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cont,
    input  logic                     spi_miso,
    input  logic                     data_ack,
    output logic                     spi_sck,
    output logic                     adc_conv,
    output logic                     busy,
    output logic [NUM_CH*DATA_W-1:0] adc_data,
    output logic                     data_valid,
    output logic                     overrun
);

    localparam int C_FRAME_BITS = NUM_CH * (GAP_BITS + DATA_W) + TAIL_BITS;
    localparam int C_PERIOD     = 2 * HALF_DIV;
    localparam int C_DIV_W      = $clog2(C_PERIOD + 1);
    localparam int C_BIT_W      = $clog2(C_FRAME_BITS + 1);

    localparam logic [C_DIV_W-1:0] C_DIV_LAST  = C_DIV_W'(C_PERIOD - 1);
    localparam logic [C_DIV_W-1:0] C_HALF      = C_DIV_W'(HALF_DIV);
    localparam logic [C_DIV_W-1:0] C_HALF_LAST = C_DIV_W'(HALF_DIV - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST  = C_BIT_W'(C_FRAME_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [C_DIV_W-1:0]         r_div;
    logic [C_DIV_W-1:0]         w_div_nxt;
    logic [C_BIT_W-1:0]         r_bit;
    logic [C_BIT_W-1:0]         w_bit_nxt;
    logic                       w_sck_nxt;
    logic                       w_conv_nxt;
    logic                       w_sample;
    logic [C_FRAME_BITS-1:0]    r_frame;
    logic [NUM_CH*DATA_W-1:0]   w_words;
    logic                       w_unused_bits;

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_sck_nxt   = 1'b0;
        w_conv_nxt  = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start || cont) begin
                    w_state_nxt = S_CONV;
                    w_div_nxt   = '0;
                    w_conv_nxt  = 1'b1;
                end
            end
            S_CONV: begin
                if (r_div == C_DIV_LAST) begin
                    w_state_nxt = S_SHIFT;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_sck_nxt   = 1'b1;
                end else begin
                    w_div_nxt  = r_div + 1'b1;
                    w_conv_nxt = 1'b1;
                end
            end
            S_SHIFT: begin
                // The edge that drops SCK is the MISO sampling point.
                w_sample = (r_div == C_HALF_LAST);
                if (r_div == C_DIV_LAST) begin
                    w_div_nxt = '0;
                    if (r_bit == C_BIT_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                        w_sck_nxt = 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                    w_sck_nxt = ((r_div + 1'b1) < C_HALF);
                end
            end
            S_DONE: begin
                if (cont) begin
                    w_state_nxt = S_CONV;
                    w_div_nxt   = '0;
                    w_conv_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Whole frame is shifted in; bit b ends up at r_frame[C_FRAME_BITS-1-b].
    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_chan
            assign w_words[c*DATA_W +: DATA_W] =
                r_frame[C_FRAME_BITS-1-c*(GAP_BITS+DATA_W)-GAP_BITS -: DATA_W];
        end
    endgenerate

    assign w_unused_bits = ^r_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_frame    <= '0;
            spi_sck    <= 1'b0;
            adc_conv   <= 1'b0;
            busy       <= 1'b0;
            adc_data   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_bit    <= w_bit_nxt;
            spi_sck  <= w_sck_nxt;
            adc_conv <= w_conv_nxt;
            busy     <= (w_state_nxt != S_IDLE);
            if (w_sample) begin
                r_frame <= {r_frame[C_FRAME_BITS-2:0], spi_miso};
            end
            if (w_state_nxt == S_DONE) begin
                adc_data   <= w_words;
                data_valid <= 1'b1;
                if (data_valid && !data_ack) begin
                    overrun <= 1'b1;
                end
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_adc_capture
// Description : Scoreboard bench for spi_adc_capture with serial ADC models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_adc_capture;

    localparam logic [13:0] C_CH0    = 14'b00001010001001;
    localparam logic [13:0] C_CH1    = 14'b00001101101001;
    localparam logic [27:0] C_EXP1   = {C_CH1, C_CH0};
    localparam logic [33:0] C_P_NORM = {2'b00, C_CH0, 2'b00, C_CH1, 2'b00};
    localparam logic [33:0] C_P_GAP  = {2'b11, C_CH0, 2'b11, C_CH1, 2'b11};
    localparam logic [51:0] C_P2     = {1'b0, 12'hA5C, 1'b0, 12'h3F0, 1'b0, 12'h001, 1'b0, 12'hFFF};
    localparam logic [47:0] C_EXP2   = {12'hFFF, 12'h001, 12'h3F0, 12'hA5C};

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst, start, cont, data_ack, start2;
    logic spi_miso = 1'b0;
    logic spi_miso2 = 1'b0;
    logic sck1, conv1, busy1, dv1, ovr1;
    logic sck2, conv2, busy2, dv2, ovr2;
    logic [27:0] data1;
    logic [47:0] data2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int conv_hi1 = 0;
    int conv_rise1 = 0;
    int sck_rise1 = 0;
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [33:0] pat1 = C_P_NORM;
    int bidx1 = 0;
    int bidx2 = 0;

    spi_adc_capture u_dut1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .spi_miso(spi_miso),
        .data_ack(data_ack), .spi_sck(sck1), .adc_conv(conv1), .busy(busy1),
        .adc_data(data1), .data_valid(dv1), .overrun(ovr1)
    );

    spi_adc_capture #(
        .DATA_W(12), .NUM_CH(4), .GAP_BITS(1), .TAIL_BITS(0), .HALF_DIV(1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .cont(1'b0), .spi_miso(spi_miso2),
        .data_ack(1'b0), .spi_sck(sck2), .adc_conv(conv2), .busy(busy2),
        .adc_data(data2), .data_valid(dv2), .overrun(ovr2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: new bit on each rising SCK, bit counter restarts on CONV.
    always @(posedge sck1 or posedge conv1) begin
        if (conv1) bidx1 = 0;
        else begin
            spi_miso = (bidx1 < 34) ? pat1[33-bidx1] : 1'b0;
            bidx1++;
        end
    end

    always @(posedge sck2 or posedge conv2) begin
        if (conv2) bidx2 = 0;
        else begin
            spi_miso2 = (bidx2 < 52) ? C_P2[51-bidx2] : 1'b0;
            bidx2++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic pv1 = 1'b0, pv2 = 1'b0, ps1 = 1'b0, pc1 = 1'b0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (conv1) conv_hi1++;
            if (conv1 && !pc1) conv_rise1++;
            if (sck1 && !ps1) sck_rise1++;
            if (dv1 && !pv1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb1_unexpected actual=%0h required=none", data1);
                end else begin
                    e = q1.pop_front();
                    chk("sb1_data", {36'd0, data1}, e);
                end
            end
            if (dv2 && !pv2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb2_unexpected actual=%0h required=none", data2);
                end else begin
                    e = q2.pop_front();
                    chk("sb2_data", {16'd0, data2}, e);
                end
            end
            pv1 = dv1; pv2 = dv2; ps1 = sck1; pc1 = conv1;
        end
    endtask

    task automatic wait_rise(input int which, input int budget, output int t);
        int n = 0;
        logic v;
        do begin
            @(negedge clk);
            v = (which == 1) ? dv1 : dv2;
            n++;
        end while (!v && n < budget);
        if (!v) begin
            checks++; errors++;
            $display("FAIL timeout_valid%0d actual=0 required=1", which);
        end
        t = cyc;
    endtask

    task automatic pulse_start(output int ts);
        start = 1'b1;
        ts = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ack1();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        chk("ack_clears_valid", {63'd0, dv1}, 64'd0);
    endtask

    initial begin
        int ts, tr, t1, t2, t3, s0, c0, n0;
        rst = 1'b1; start = 1'b0; cont = 1'b0; data_ack = 1'b0; start2 = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_sck", {63'd0, sck1}, 64'd0);
        chk("rst_conv", {63'd0, conv1}, 64'd0);
        chk("rst_busy", {63'd0, busy1}, 64'd0);
        chk("rst_valid", {63'd0, dv1}, 64'd0);
        chk("rst_data", {36'd0, data1}, 64'd0);
        chk("rst_overrun", {63'd0, ovr1}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic single-shot frame
        pat1 = C_P_NORM;
        q1.push_back({36'd0, C_EXP1});
        s0 = sck_rise1; c0 = conv_hi1;
        pulse_start(ts);
        wait_rise(1, 400, tr);
        chk("latency_basic", tr - ts + 1, 141);
        chk("sck_rises", sck_rise1 - s0, 34);
        chk("conv_cycles", conv_hi1 - c0, 4);
        chk("busy_in_done", {63'd0, busy1}, 64'd1);
        ack1();

        // Gap/tail bits driven high must be discarded
        pat1 = C_P_GAP;
        q1.push_back({36'd0, C_EXP1});
        pulse_start(ts);
        wait_rise(1, 400, tr);
        chk("latency_gap", tr - ts + 1, 141);
        ack1();

        // Continuous without ack: overrun appears exactly at frame 2 DONE
        pat1 = C_P_NORM;
        q1.push_back({36'd0, C_EXP1});
        cont = 1'b1;
        wait_rise(1, 400, tr);
        chk("overrun_f1", {63'd0, ovr1}, 64'd0);
        repeat (140) @(negedge clk);
        chk("overrun_before_f2", {63'd0, ovr1}, 64'd0);
        @(negedge clk);
        chk("overrun_f2", {63'd0, ovr1}, 64'd1);
        chk("valid_held", {63'd0, dv1}, 64'd1);
        repeat (141) @(negedge clk);
        cont = 1'b0;
        chk("data_f3", {36'd0, data1}, {36'd0, C_EXP1});
        @(negedge clk);
        chk("idle_after_cont_drop", {63'd0, busy1}, 64'd0);
        chk("overrun_sticky", {63'd0, ovr1}, 64'd1);
        ack1();
        chk("overrun_survives_ack", {63'd0, ovr1}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("overrun_cleared_rst", {63'd0, ovr1}, 64'd0);

        // Continuous with ack held high: no overrun, 141-cycle period
        repeat (3) q1.push_back({36'd0, C_EXP1});
        data_ack = 1'b1;
        cont = 1'b1;
        wait_rise(1, 400, t1);
        wait_rise(1, 400, t2);
        chk("period_1", t2 - t1, 141);
        wait_rise(1, 400, t3);
        chk("period_2", t3 - t2, 141);
        cont = 1'b0;
        @(negedge clk);
        data_ack = 1'b0;
        chk("no_overrun_acked", {63'd0, ovr1}, 64'd0);
        chk("valid_cleared_acked", {63'd0, dv1}, 64'd0);
        chk("idle_after_acked_run", {63'd0, busy1}, 64'd0);

        // start and cont activity during SHIFT produce only one frame
        q1.push_back({36'd0, C_EXP1});
        n0 = conv_rise1;
        cont = 1'b1;
        pulse_start(ts);
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        cont = 1'b0;
        wait_rise(1, 400, tr);
        chk("latency_cont_drop", tr - ts + 1, 141);
        chk("busy_at_valid", {63'd0, busy1}, 64'd1);
        @(negedge clk);
        chk("busy_falls_after_done", {63'd0, busy1}, 64'd0);
        repeat (300) @(negedge clk);
        chk("single_frame", conv_rise1 - n0, 1);
        chk("valid_kept", {63'd0, dv1}, 64'd1);

        // Reset in the middle of bit 20
        pulse_start(ts);
        repeat (85) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_sck", {63'd0, sck1}, 64'd0);
        chk("midrst_conv", {63'd0, conv1}, 64'd0);
        chk("midrst_busy", {63'd0, busy1}, 64'd0);
        chk("midrst_data", {36'd0, data1}, 64'd0);
        chk("midrst_valid", {63'd0, dv1}, 64'd0);
        q1.push_back({36'd0, C_EXP1});
        pulse_start(ts);
        wait_rise(1, 400, tr);
        chk("latency_after_rst", tr - ts + 1, 141);
        ack1();

        // Four-channel, HALF_DIV=1 instance
        q2.push_back({16'd0, C_EXP2});
        start2 = 1'b1;
        ts = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        wait_rise(2, 300, tr);
        chk("latency_dut2", tr - ts + 1, 107);
        chk("overrun_dut2", {63'd0, ovr2}, 64'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q1.size() + q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
